// File: rtl/reg_file_mp_if.sv
// Command, output-channel and ALU read-port bundle between the decoder side
// (master) and the register file (slave).
interface reg_file_mp_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             ena;
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       opcode;
   logic [AW-1:0]    rd;
   logic [AW-1:0]    rs;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    rpa_addr;
   logic [WIDTH-1:0] rpa_data;
   logic [AW-1:0]    rpb_addr;
   logic [WIDTH-1:0] rpb_data;

   modport master (
      output ena, op_valid, opcode, rd, rs, data_in, out_ready, rpa_addr, rpb_addr,
      input  op_ready, out_data, out_valid, rpa_data, rpb_data
   );

   modport slave (
      input  ena, op_valid, opcode, rd, rs, data_in, out_ready, rpa_addr, rpb_addr,
      output op_ready, out_data, out_valid, rpa_data, rpb_data
   );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised register file executing one register-transfer op per accepted
// command, with two combinational read ports and a back-pressured output channel.
module reg_file_mp #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic           clock,
   input logic           reset,
   reg_file_mp_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_LOAD   = 3'b000,
      OP_MOV    = 3'b001,
      OP_SWAP   = 3'b010,
      OP_OUT    = 3'b011,
      OP_CLR    = 3'b100,
      OP_INC    = 3'b101,
      OP_CLRALL = 3'b110,
      OP_NOP    = 3'b111
   } opcode_e;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] outData_q, outData_d;
   logic             outValid_q, outValid_d;
   logic             accept;
   logic             wrEn, swapEn, clrAll;
   logic [WIDTH-1:0] wrVal;

   // Index decode by matching against every slot, so indices >= DEPTH read 0.
   function automatic logic [WIDTH-1:0] readReg(input logic [AW-1:0] addr);
      readReg = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (AW'(i) == addr) readReg = regs_q[i];
      end
   endfunction

   function automatic logic inRange(input logic [AW-1:0] addr);
      inRange = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (AW'(i) == addr) inRange = 1'b1;
      end
   endfunction

   assign bus.op_ready  = reset & bus.ena & (~outValid_q | bus.out_ready);
   assign accept        = bus.op_valid & bus.op_ready;
   assign bus.out_data  = outData_q;
   assign bus.out_valid = outValid_q;
   assign bus.rpa_data  = readReg(bus.rpa_addr);
   assign bus.rpb_data  = readReg(bus.rpb_addr);

   always_comb begin
      regs_d     = regs_q;
      outData_d  = outData_q;
      outValid_d = outValid_q;
      wrEn       = 1'b0;
      wrVal      = '0;
      swapEn     = 1'b0;
      clrAll     = 1'b0;

      if (outValid_q && bus.out_ready) outValid_d = 1'b0;

      if (accept) begin
         case (opcode_e'(bus.opcode))
            OP_LOAD: begin
               wrEn  = 1'b1;
               wrVal = bus.data_in;
            end
            OP_MOV: begin
               wrEn  = 1'b1;
               wrVal = readReg(bus.rs);
            end
            OP_SWAP:   swapEn = inRange(bus.rd) & inRange(bus.rs);
            OP_OUT: begin
               outData_d  = readReg(bus.rs);
               outValid_d = 1'b1;
            end
            OP_CLR: begin
               wrEn  = 1'b1;
               wrVal = '0;
            end
            OP_INC: begin
               wrEn  = 1'b1;
               wrVal = readReg(bus.rd) + WIDTH'(1);
            end
            OP_CLRALL: clrAll = 1'b1;
            default:   ;
         endcase
      end

      // Writes only land on in-range slots; an out-of-range rd matches nothing.
      for (int i = 0; i < DEPTH; i++) begin
         if (clrAll) begin
            regs_d[i] = '0;
         end else if (swapEn) begin
            if (AW'(i) == bus.rd)      regs_d[i] = readReg(bus.rs);
            else if (AW'(i) == bus.rs) regs_d[i] = readReg(bus.rd);
         end else if (wrEn && (AW'(i) == bus.rd)) begin
            regs_d[i] = wrVal;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
         outData_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
      end
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a DEPTH=4 instance driven from a vector table with an
// output scoreboard, and a DEPTH=3 instance for out-of-range and async reset.
module tb_reg_file_mp;
   logic clock;
   logic resetA, resetB;

   reg_file_mp_if #(.WIDTH(8), .DEPTH(4)) ifA ();
   reg_file_mp_if #(.WIDTH(8), .DEPTH(3)) ifB ();

   reg_file_mp #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dutA (
      .clock (clock),
      .reset (resetA),
      .bus   (ifA.slave)
   );

   reg_file_mp #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) dutB (
      .clock (clock),
      .reset (resetB),
      .bus   (ifB.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic       ena;
      logic       opValid;
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] din;
      logic       outReady;
      logic [1:0] ra;
      logic [1:0] rb;
      logic       expReady;
      logic [7:0] expA;
      logic [7:0] expB;
      logic       expOutValid;
      logic [7:0] expOut;
   } vec_t;

   localparam logic [2:0] LOAD = 3'b000, MOV = 3'b001, SWAP = 3'b010, OUT = 3'b011,
                          CLR = 3'b100, INC = 3'b101, CLRALL = 3'b110, NOP = 3'b111;

   vec_t       vecs[$];
   logic [7:0] sbQ[$];
   int         passCount = 0;
   int         totalCount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic en, input logic v, input logic [2:0] op,
                               input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] din,
                               input logic ordy, input logic [1:0] ra, input logic [1:0] rb,
                               input logic eRdy, input logic [7:0] eA, input logic [7:0] eB,
                               input logic eOv, input logic [7:0] eOut);
      vec_t t;
      t.ena = en; t.opValid = v; t.op = op; t.rd = rd; t.rs = rs; t.din = din;
      t.outReady = ordy; t.ra = ra; t.rb = rb; t.expReady = eRdy; t.expA = eA;
      t.expB = eB; t.expOutValid = eOv; t.expOut = eOut;
      return t;
   endfunction

   task automatic applyStimulus(input vec_t t);
      @(posedge clock);
      #1;
      ifA.ena       = t.ena;
      ifA.op_valid  = t.opValid;
      ifA.opcode    = t.op;
      ifA.rd        = t.rd;
      ifA.rs        = t.rs;
      ifA.data_in   = t.din;
      ifA.out_ready = t.outReady;
      ifA.rpa_addr  = t.ra;
      ifA.rpb_addr  = t.rb;
      if (t.opValid && t.op == OUT && t.expReady) sbQ.push_back(t.expOut);
   endtask

   task automatic checkOutput(input vec_t t, input int idx);
      #2;
      check($sformatf("v%0d_op_ready", idx), ifA.op_ready, t.expReady);
      check($sformatf("v%0d_rpa", idx), ifA.rpa_data, t.expA);
      check($sformatf("v%0d_rpb", idx), ifA.rpb_data, t.expB);
      check($sformatf("v%0d_out_valid", idx), ifA.out_valid, t.expOutValid);
   endtask

   // Each drained output word is compared against the oldest expected OUT value.
   always @(negedge clock) begin
      if (resetA && ifA.out_valid && ifA.out_ready) begin
         if (sbQ.size() == 0) check("sb_unexpected_out", 1, 0);
         else check("sb_out_data", ifA.out_data, sbQ.pop_front());
      end
   end

   task automatic driveB(input logic v, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [7:0] din, input logic ordy,
                         input logic [1:0] ra, input logic [1:0] rb);
      @(posedge clock);
      #1;
      ifB.op_valid  = v;
      ifB.opcode    = op;
      ifB.rd        = rd;
      ifB.rs        = rs;
      ifB.data_in   = din;
      ifB.out_ready = ordy;
      ifB.rpa_addr  = ra;
      ifB.rpb_addr  = rb;
      #2;
   endtask

   initial begin
      resetA = 1'b0; resetB = 1'b0;
      ifA.ena = 1'b1; ifA.op_valid = 1'b0; ifA.opcode = NOP; ifA.rd = '0; ifA.rs = '0;
      ifA.data_in = '0; ifA.out_ready = 1'b1; ifA.rpa_addr = '0; ifA.rpb_addr = '0;
      ifB.ena = 1'b1; ifB.op_valid = 1'b0; ifB.opcode = NOP; ifB.rd = '0; ifB.rs = '0;
      ifB.data_in = '0; ifB.out_ready = 1'b1; ifB.rpa_addr = '0; ifB.rpb_addr = '0;

      #2;
      check("rst_op_ready", ifA.op_ready, 0);
      check("rst_out_valid", ifA.out_valid, 0);
      check("rst_out_data", ifA.out_data, 8'h00);
      @(negedge clock);
      resetA = 1'b1; resetB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ifA.rpa_addr = 2'(i);
         #1;
         check($sformatf("rst_val_r%0d", i), ifA.rpa_data, 8'h5A);
      end

      //                ena v  op      rd rs din    ordy ra rb rdy expA   expB   ov out
      vecs.push_back(mk(1, 1, LOAD,   2, 0, 8'h3C, 1, 2, 0, 1, 8'h5A, 8'h5A, 0, 0));
      vecs.push_back(mk(1, 1, NOP,    0, 0, 8'h00, 1, 2, 3, 1, 8'h3C, 8'h5A, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   0, 0, 8'h11, 1, 1, 3, 1, 8'h5A, 8'h5A, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   1, 0, 8'h22, 1, 0, 0, 1, 8'h11, 8'h11, 0, 0));
      vecs.push_back(mk(1, 1, SWAP,   0, 1, 8'h00, 1, 0, 1, 1, 8'h11, 8'h22, 0, 0));
      vecs.push_back(mk(1, 1, MOV,    3, 0, 8'h00, 1, 0, 1, 1, 8'h22, 8'h11, 0, 0));
      vecs.push_back(mk(1, 1, SWAP,   1, 1, 8'h00, 1, 3, 1, 1, 8'h22, 8'h11, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   2, 0, 8'hFF, 1, 1, 2, 1, 8'h11, 8'h3C, 0, 0));
      vecs.push_back(mk(1, 1, INC,    2, 0, 8'h00, 1, 2, 3, 1, 8'hFF, 8'h22, 0, 0));
      vecs.push_back(mk(1, 1, CLR,    1, 0, 8'h00, 1, 2, 1, 1, 8'h00, 8'h11, 0, 0));
      vecs.push_back(mk(0, 1, LOAD,   0, 0, 8'h77, 1, 1, 0, 0, 8'h00, 8'h22, 0, 0));
      vecs.push_back(mk(1, 1, INC,    3, 0, 8'h00, 1, 0, 1, 1, 8'h22, 8'h00, 0, 0));
      vecs.push_back(mk(1, 1, CLRALL, 0, 0, 8'h00, 1, 3, 2, 1, 8'h23, 8'h00, 0, 0));
      vecs.push_back(mk(1, 1, NOP,    0, 0, 8'h00, 1, 0, 3, 1, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   0, 0, 8'hA5, 1, 1, 2, 1, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(1, 1, OUT,    0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 8'hA5, 0, 8'hA5));
      vecs.push_back(mk(1, 1, LOAD,   1, 0, 8'h99, 0, 1, 0, 0, 8'h00, 8'hA5, 1, 0));
      vecs.push_back(mk(1, 1, LOAD,   1, 0, 8'h99, 0, 1, 0, 0, 8'h00, 8'hA5, 1, 0));
      vecs.push_back(mk(1, 1, LOAD,   1, 0, 8'h99, 0, 1, 0, 0, 8'h00, 8'hA5, 1, 0));
      vecs.push_back(mk(1, 1, LOAD,   1, 0, 8'h99, 1, 1, 0, 1, 8'h00, 8'hA5, 1, 0));
      vecs.push_back(mk(1, 1, NOP,    0, 0, 8'h00, 1, 1, 0, 1, 8'h99, 8'hA5, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   0, 0, 8'h01, 1, 1, 0, 1, 8'h99, 8'hA5, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   1, 0, 8'h02, 1, 0, 1, 1, 8'h01, 8'h99, 0, 0));
      vecs.push_back(mk(1, 1, LOAD,   2, 0, 8'h03, 1, 1, 2, 1, 8'h02, 8'h00, 0, 0));
      vecs.push_back(mk(1, 1, OUT,    0, 0, 8'h00, 1, 2, 0, 1, 8'h03, 8'h01, 0, 8'h01));
      vecs.push_back(mk(1, 1, OUT,    0, 1, 8'h00, 1, 2, 0, 1, 8'h03, 8'h01, 1, 8'h02));
      vecs.push_back(mk(1, 1, OUT,    0, 2, 8'h00, 1, 2, 0, 1, 8'h03, 8'h01, 1, 8'h03));
      vecs.push_back(mk(1, 1, NOP,    0, 0, 8'h00, 1, 2, 0, 1, 8'h03, 8'h01, 1, 0));
      vecs.push_back(mk(1, 1, NOP,    0, 0, 8'h00, 1, 2, 0, 1, 8'h03, 8'h01, 0, 0));
      vecs.push_back(mk(1, 1, OUT,    0, 0, 8'h00, 0, 2, 0, 1, 8'h03, 8'h01, 0, 8'h01));
      vecs.push_back(mk(0, 1, LOAD,   0, 0, 8'hFF, 1, 2, 0, 0, 8'h03, 8'h01, 1, 0));
      vecs.push_back(mk(1, 1, NOP,    0, 0, 8'h00, 1, 0, 2, 1, 8'h01, 8'h03, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end
      @(posedge clock);
      #1;
      ifA.op_valid = 1'b0;
      check("sb_all_drained", sbQ.size(), 0);

      // DEPTH=3 instance: index 3 is out of range.
      driveB(1, LOAD, 3, 0, 8'h77, 1, 0, 2);
      check("b_r0_init", ifB.rpa_data, 8'h5A);
      check("b_r2_init", ifB.rpb_data, 8'h5A);
      check("b_op_ready", ifB.op_ready, 1);
      driveB(1, MOV, 0, 3, 8'h00, 1, 0, 3);
      check("b_oor_load_no_alias", ifB.rpa_data, 8'h5A);
      check("b_oor_read", ifB.rpb_data, 8'h00);
      driveB(1, SWAP, 1, 3, 8'h00, 1, 0, 1);
      check("b_mov_from_oor", ifB.rpa_data, 8'h00);
      driveB(1, LOAD, 1, 0, 8'h44, 1, 1, 0);
      check("b_swap_oor_noop", ifB.rpa_data, 8'h5A);
      driveB(1, OUT, 0, 1, 8'h00, 1, 1, 0);
      check("b_load_r1", ifB.rpa_data, 8'h44);
      driveB(1, OUT, 0, 3, 8'h00, 1, 1, 0);
      check("b_out_valid", ifB.out_valid, 1);
      check("b_out_data_r1", ifB.out_data, 8'h44);
      driveB(0, NOP, 0, 0, 8'h00, 0, 1, 0);
      check("b_out_oor_valid", ifB.out_valid, 1);
      check("b_out_oor_data", ifB.out_data, 8'h00);
      check("b_stall_ready", ifB.op_ready, 0);
      driveB(1, LOAD, 1, 0, 8'hEE, 0, 1, 0);
      check("b_stall_valid", ifB.out_valid, 1);
      check("b_stall_ready2", ifB.op_ready, 0);

      // Reset between edges must clear everything without a clock.
      #1;
      resetB = 1'b0;
      #1;
      check("b_async_out_valid", ifB.out_valid, 0);
      check("b_async_op_ready", ifB.op_ready, 0);
      check("b_async_r1", ifB.rpa_data, 8'h5A);
      check("b_async_r0", ifB.rpb_data, 8'h5A);
      @(negedge clock);
      resetB = 1'b1;
      ifB.op_valid = 1'b0;
      @(posedge clock);
      #1;
      check("b_after_reset_r1", ifB.rpa_data, 8'h5A);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end
endmodule
